// File: rtl/acfa_pkg.sv
// rtl/acfa_pkg.sv - shared types and constants for the CFLog write sequencer
package acfa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SRC,
    ST_WR_DST,
    ST_WR_CTR,
    ST_WAIT_TCB
  } state_t;

  localparam logic        CTR_TAG   = 1'b1;
  localparam logic [14:0] SAT15_MAX = 15'h7FFF;

  // One control-flow event; ctr_word is precomputed so a pended loop event replays unchanged.
  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dest;
    logic        is_loop;
    logic [15:0] ctr_word;
  } event_t;

endpackage

// File: rtl/cflog_event_fifo1.sv
// rtl/cflog_event_fifo1.sv - one-deep pending event slot with sticky drop flag
module cflog_event_fifo1
  import acfa_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  event_t push_data,
  input  logic   pop,
  input  logic   clear,
  input  logic   drop,
  output logic   valid,
  output event_t data,
  output logic   overflow
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      data     <= '0;
      overflow <= 1'b0;
    end else begin
      if (clear) begin
        valid <= 1'b0;
      end else if (push && (!valid || pop)) begin
        valid <= 1'b1;
        data  <= push_data;
      end else if (pop) begin
        valid <= 1'b0;
      end
      // A push into a slot that is not being drained this cycle loses the event.
      if (drop || (push && valid && !pop)) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cflog_controller.sv
// rtl/cflog_controller.sv - sequences branch/loop events into CFLog slices and
// hands full or flushed slices to the TCB via acfa_nmi
module cflog_controller
  import acfa_pkg::*;
#(
  parameter int LOG_WORDS   = 256,
  parameter int LOG_AW      = 8,
  parameter int SLICE_WORDS = 64,
  parameter int CTR_SIZE    = 32
) (
  input  logic                clk,
  input  logic                puc_rst,
  input  logic                branch_detect,
  input  logic [15:0]         src_pc,
  input  logic [15:0]         dest_pc,
  input  logic                loop_detect,
  input  logic [CTR_SIZE-1:0] loop_ctr,
  input  logic                flush_req,
  input  logic                tcb_done,
  output logic                log_we,
  output logic [LOG_AW-1:0]   log_addr,
  output logic [15:0]         log_wdata,
  output logic                acfa_nmi,
  output logic [LOG_AW-1:0]   slice_base,
  output logic [LOG_AW:0]     slice_len,
  output logic                log_busy,
  output logic                overflow
);

  localparam logic [LOG_AW-1:0] SLICE     = LOG_AW'(SLICE_WORDS);
  localparam logic [LOG_AW-1:0] ADDR_MASK = LOG_AW'(LOG_WORDS - 1);
  localparam logic [LOG_AW-1:0] ONE       = LOG_AW'(1);
  localparam logic [LOG_AW-1:0] TWO       = LOG_AW'(2);

  state_t state, state_next;

  logic [LOG_AW-1:0] ptr, ctr_addr, wr_addr, base;
  logic [15:0]       wr_data, dst_q;
  logic              loop_active, flush_pend, nmi_q;
  logic [LOG_AW:0]   len_q;

  event_t            in_ev, pend_ev, ev;
  logic              pend_valid, ev_valid;
  logic              push, pop, clear, drop, close;
  logic [LOG_AW-1:0] ptr_done, room, base_next;
  logic [14:0]       ctr15;

  assign ctr15 = (loop_ctr > CTR_SIZE'(SAT15_MAX)) ? SAT15_MAX : loop_ctr[14:0];
  assign in_ev = '{src: src_pc, dest: dest_pc, is_loop: loop_detect,
                   ctr_word: {ctr15, CTR_TAG}};

  // Pointer as it stands once the current entry completes; a counter entry already advanced it.
  assign ptr_done  = (state == ST_WR_DST) ? ptr + TWO : ptr;
  assign room      = base + SLICE - ptr_done;
  assign base_next = (ptr + SLICE - ONE) & ~(SLICE - ONE) & ADDR_MASK;

  cflog_event_fifo1 u_pend (
    .clk       (clk),
    .rst       (puc_rst),
    .push      (push),
    .push_data (in_ev),
    .pop       (pop),
    .clear     (clear),
    .drop      (drop),
    .valid     (pend_valid),
    .data      (pend_ev),
    .overflow  (overflow)
  );

  always_comb begin
    state_next = state;
    push       = 1'b0;
    pop        = 1'b0;
    clear      = 1'b0;
    drop       = 1'b0;
    close      = 1'b0;
    ev         = in_ev;
    ev_valid   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend_valid) begin
          ev       = pend_ev;
          ev_valid = 1'b1;
          pop      = 1'b1;
          push     = branch_detect;
        end else begin
          ev_valid = branch_detect;
        end
        if (ev_valid) begin
          state_next = ev.is_loop ? ST_WR_CTR : ST_WR_SRC;
        end else if (flush_req || flush_pend) begin
          close      = 1'b1;
          state_next = ST_WAIT_TCB;
        end
      end
      ST_WR_SRC: begin
        push       = branch_detect;
        state_next = ST_WR_DST;
      end
      ST_WR_DST, ST_WR_CTR: begin
        push = branch_detect;
        if (room < TWO || flush_pend || flush_req) begin
          close      = 1'b1;
          state_next = ST_WAIT_TCB;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_TCB: begin
        clear = 1'b1;
        drop  = branch_detect;
        if (tcb_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (puc_rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      base        <= '0;
      ctr_addr    <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      dst_q       <= '0;
      loop_active <= 1'b0;
      flush_pend  <= 1'b0;
      nmi_q       <= 1'b0;
      len_q       <= '0;
    end else begin
      state <= state_next;
      nmi_q <= close;
      if (close) len_q <= {1'b0, ptr_done - base};
      if (state == ST_WAIT_TCB)  flush_pend <= 1'b0;
      else if (flush_req)        flush_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (ev_valid && ev.is_loop) begin
            wr_data <= ev.ctr_word;
            if (loop_active) begin
              wr_addr <= ctr_addr;
            end else begin
              wr_addr     <= ptr;
              ctr_addr    <= ptr;
              ptr         <= ptr + ONE;
              loop_active <= 1'b1;
            end
          end else if (ev_valid) begin
            wr_addr     <= ptr;
            wr_data     <= ev.src;
            dst_q       <= ev.dest;
            loop_active <= 1'b0;
          end
        end
        ST_WR_SRC: begin
          wr_addr <= ptr + ONE;
          wr_data <= dst_q;
        end
        ST_WR_DST: ptr <= ptr_done;
        ST_WAIT_TCB: begin
          if (tcb_done) begin
            base        <= base_next;
            ptr         <= base_next;
            loop_active <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign log_we     = (state == ST_WR_SRC) || (state == ST_WR_DST) || (state == ST_WR_CTR);
  assign log_addr   = wr_addr;
  assign log_wdata  = wr_data;
  assign acfa_nmi   = nmi_q;
  assign slice_base = base;
  assign slice_len  = len_q;
  assign log_busy   = (state == ST_WAIT_TCB);

endmodule
